// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions and the
// default processor ID.
package cp0_unit_pkg;

   localparam int HW_INT_W = 6;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam int SR_IE_BIT  = 0;
   localparam int SR_EXL_BIT = 1;
   localparam int SR_IM_LSB  = 10;
   localparam int SR_IM_MSB  = 15;
   localparam int CAUSE_IP_LSB = 10;
   localparam int CAUSE_IP_MSB = 15;

   localparam logic [31:0] PRID_DEFAULT = 32'h0000_3000;

   // Exception PCs are always word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Multi-stage synchronizer bringing the asynchronous hw_int lines into the
// clk domain.
module cp0_int_sync
   import cp0_unit_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [HW_INT_W-1:0] hw_int,
   output logic [HW_INT_W-1:0] hw_int_sync
);

   logic [SYNC_STAGES-1:0][HW_INT_W-1:0] sync_q;
   logic [SYNC_STAGES-1:0][HW_INT_W-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], hw_int};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign hw_int_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_unit.sv
// Minimal MIPS-style coprocessor 0: SR, Cause, EPC, PRId plus the interrupt
// request logic feeding the pipeline controller.
module cp0_unit
   import cp0_unit_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE  = PRID_DEFAULT,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [HW_INT_W-1:0] hw_int,
   input  logic                exl_set,
   input  logic                exl_clr,
   input  logic [31:0]         victim_pc,
   input  logic                cp0_we,
   input  logic [4:0]          cp0_addr,
   input  logic [31:0]         cp0_wdata,
   output logic [31:0]         cp0_rdata,
   output logic                int_req,
   output logic [31:0]         epc_out,
   output logic                exl_out
);

   logic [HW_INT_W-1:0] hw_int_sync;
   logic [HW_INT_W-1:0] ip_q, ip_d;
   logic [HW_INT_W-1:0] im_q, im_d;
   logic                exl_q, exl_d;
   logic                ie_q, ie_d;
   logic [31:0]         epc_q, epc_d;
   logic                sr_we, epc_we;

   cp0_int_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_int_sync (
      .clk         (clk),
      .reset       (reset),
      .hw_int      (hw_int),
      .hw_int_sync (hw_int_sync)
   );

   assign sr_we  = cp0_we && (cp0_addr == CP0_SR);
   assign epc_we = cp0_we && (cp0_addr == CP0_EPC);

   // Later assignments win: exl_set over exl_clr over an mtc0 SR/EPC write.
   always_comb begin
      ip_d  = hw_int_sync;
      im_d  = im_q;
      ie_d  = ie_q;
      exl_d = exl_q;
      epc_d = epc_q;
      if (sr_we) begin
         im_d  = cp0_wdata[SR_IM_MSB:SR_IM_LSB];
         exl_d = cp0_wdata[SR_EXL_BIT];
         ie_d  = cp0_wdata[SR_IE_BIT];
      end
      if (epc_we) begin
         epc_d = word_align(cp0_wdata);
      end
      if (exl_clr) begin
         exl_d = 1'b0;
      end
      if (exl_set) begin
         exl_d = 1'b1;
         epc_d = word_align(victim_pc);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ip_q  <= '0;
         im_q  <= '0;
         ie_q  <= 1'b0;
         exl_q <= 1'b0;
         epc_q <= '0;
      end else begin
         ip_q  <= ip_d;
         im_q  <= im_d;
         ie_q  <= ie_d;
         exl_q <= exl_d;
         epc_q <= epc_d;
      end
   end

   // Pre-write register values; a same-cycle mtc0 is not forwarded.
   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         CP0_SR:    cp0_rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
         CP0_CAUSE: cp0_rdata = {16'b0, ip_q, 10'b0};
         CP0_EPC:   cp0_rdata = epc_q;
         CP0_PRID:  cp0_rdata = PRID_VALUE;
         default:   cp0_rdata = '0;
      endcase
   end

   // Flop-only request path so exl_set cannot loop back into int_req.
   assign int_req = (|(ip_q & im_q)) & ie_q & ~exl_q;
   assign epc_out = epc_q;
   assign exl_out = exl_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios followed by random
// traffic, all compared against a register-level behavioural model.
module tb_cp0_unit;

   localparam int          SYNC = 2;
   localparam logic [31:0] PRID = 32'h0000_3000;

   logic        clk;
   logic        reset;
   logic [5:0]  hw_int;
   logic        exl_set;
   logic        exl_clr;
   logic [31:0] victim_pc;
   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic        int_req;
   logic [31:0] epc_out;
   logic        exl_out;

   int checks = 0;
   int errors = 0;

   logic [5:0]  m_im;
   logic        m_ie;
   logic        m_exl;
   logic [31:0] m_epc;
   logic [5:0]  m_hist[$];

   cp0_unit #(
      .PRID_VALUE  (PRID),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .hw_int    (hw_int),
      .exl_set   (exl_set),
      .exl_clr   (exl_clr),
      .victim_pc (victim_pc),
      .cp0_we    (cp0_we),
      .cp0_addr  (cp0_addr),
      .cp0_wdata (cp0_wdata),
      .cp0_rdata (cp0_rdata),
      .int_req   (int_req),
      .epc_out   (epc_out),
      .exl_out   (exl_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // IP shows the hw_int level applied SYNC+1 clock edges earlier.
   function automatic logic [5:0] m_ip();
      return m_hist[SYNC];
   endfunction

   function automatic logic m_int_req();
      return (|(m_ip() & m_im)) && m_ie && !m_exl;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] addr);
      logic [31:0] v;
      v = 32'd0;
      if (addr == 5'd12) v = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      else if (addr == 5'd13) v = 32'(m_ip()) << 10;
      else if (addr == 5'd14) v = m_epc;
      else if (addr == 5'd15) v = PRID;
      return v;
   endfunction

   task automatic model_reset();
      m_im  = 6'd0;
      m_ie  = 1'b0;
      m_exl = 1'b0;
      m_epc = 32'd0;
      m_hist.delete();
      repeat (SYNC + 1) m_hist.push_front(6'd0);
   endtask

   task automatic check_output(input string tag);
      check({tag, "_rdata"},   cp0_rdata, m_read(cp0_addr));
      check({tag, "_int_req"}, 32'(int_req), 32'(m_int_req()));
      check({tag, "_exl"},     32'(exl_out), 32'(m_exl));
      check({tag, "_epc"},     epc_out, m_epc);
   endtask

   // One clock cycle: drive after the falling edge, check pre-edge values,
   // advance the model on the rising edge, return at the next falling edge.
   task automatic apply_stimulus(input logic we, input logic [4:0] addr,
                                 input logic [31:0] wdata, input logic set,
                                 input logic clr, input logic [31:0] vpc,
                                 input logic [5:0] hw);
      cp0_we    = we;
      cp0_addr  = addr;
      cp0_wdata = wdata;
      exl_set   = set;
      exl_clr   = clr;
      victim_pc = vpc;
      hw_int    = hw;
      #1;
      check_output("cycle");
      @(posedge clk);
      if (set) m_exl = 1'b1;
      else if (clr) m_exl = 1'b0;
      else if (we && addr == 5'd12) m_exl = wdata[1];
      if (we && addr == 5'd12) begin
         m_im = wdata[15:10];
         m_ie = wdata[0];
      end
      if (set) m_epc = vpc & ~32'd3;
      else if (we && addr == 5'd14) m_epc = wdata & ~32'd3;
      m_hist.push_front(hw);
      void'(m_hist.pop_back());
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      logic        r_we;
      logic [4:0]  r_addr;
      logic [31:0] r_wdata;
      logic        r_set;
      logic        r_clr;
      logic [31:0] r_vpc;
      logic [5:0]  r_hw;
      int          sel;

      reset     = 1'b0;
      hw_int    = 6'd0;
      exl_set   = 1'b0;
      exl_clr   = 1'b0;
      victim_pc = 32'd0;
      cp0_we    = 1'b0;
      cp0_addr  = 5'd12;
      cp0_wdata = 32'd0;
      model_reset();

      repeat (2) @(negedge clk);
      #1;
      check("reset_int_req", 32'(int_req), 32'd0);
      check("reset_exl", 32'(exl_out), 32'd0);
      check("reset_epc", epc_out, 32'd0);
      check("reset_sr", cp0_rdata, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      $display("[TB] enable IM0/IE and raise hw_int[0]");
      apply_stimulus(1'b1, 5'd12, 32'h0000_0401, 1'b0, 1'b0, 32'd0, 6'd0);
      for (int i = 1; i <= SYNC + 1; i++) begin
         apply_stimulus(1'b0, 5'd13, 32'd0, 1'b0, 1'b0, 32'd0, 6'b000001);
         check("int_req_latency", 32'(int_req), (i == SYNC + 1) ? 32'd1 : 32'd0);
      end
      cp0_addr = 5'd13;
      #1;
      check("cause_read", cp0_rdata, 32'h0000_0400);

      $display("[TB] take interrupt, then eret");
      apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h0000_3047, 6'b000001);
      check("take_exl", 32'(exl_out), 32'd1);
      check("take_int_req", 32'(int_req), 32'd0);
      check("take_epc", epc_out, 32'h0000_3044);
      apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0, 6'b000001);
      check("eret_exl", 32'(exl_out), 32'd0);
      check("eret_int_req", 32'(int_req), 32'd1);

      $display("[TB] priority collisions");
      apply_stimulus(1'b1, 5'd14, 32'h0000_4000, 1'b1, 1'b0, 32'h0000_3010, 6'b000001);
      check("epc_priority", epc_out, 32'h0000_3010);
      apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'h0000_3010, 6'b000001);
      check("exl_priority", 32'(exl_out), 32'd1);

      $display("[TB] ignored writes and fixed reads");
      apply_stimulus(1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 6'b000001);
      apply_stimulus(1'b1, 5'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 6'b000001);
      cp0_we   = 1'b0;
      cp0_addr = 5'd15;
      #1;
      check("prid_read", cp0_rdata, 32'h0000_3000);
      cp0_addr = 5'd7;
      #1;
      check("unimpl_read", cp0_rdata, 32'd0);
      cp0_addr = 5'd12;
      #1;
      check("sr_after_ignored", cp0_rdata, 32'h0000_0403);
      @(negedge clk);

      $display("[TB] reset while EXL set");
      apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h0000_3044, 6'b000001);
      check("pre_reset_epc", epc_out, 32'h0000_3044);
      check("pre_reset_exl", 32'(exl_out), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_int_req", 32'(int_req), 32'd0);
      check("async_reset_exl", 32'(exl_out), 32'd0);
      check("async_reset_epc", epc_out, 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(1'b0, 5'd14, 32'd0, 1'b0, 1'b0, 32'd0, 6'b000001);
      end
      check("post_reset_int_req", 32'(int_req), 32'd0);
      cp0_addr = 5'd14;
      #1;
      check("post_reset_epc_read", cp0_rdata, 32'd0);
      @(negedge clk);

      $display("[TB] random traffic");
      r_hw = 6'd0;
      for (int n = 0; n < 400; n++) begin
         sel     = int'($urandom_range(0, 5));
         r_addr  = (sel < 4) ? 5'(12 + sel) : 5'($urandom_range(0, 31));
         r_we    = ($urandom_range(0, 2) == 0);
         r_wdata = $urandom;
         if ($urandom_range(0, 3) != 0) r_wdata = r_wdata | 32'd1;
         r_set   = ($urandom_range(0, 7) == 0);
         r_clr   = ($urandom_range(0, 5) == 0);
         r_vpc   = $urandom;
         if ($urandom_range(0, 5) == 0) r_hw = 6'($urandom_range(0, 63));
         apply_stimulus(r_we, r_addr, r_wdata, r_set, r_clr, r_vpc, r_hw);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
